// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline register between stages (head + skid, strict FIFO order).
// Latency: one cycle. Backpressure: in_ready is registered and drops only when both entries are held.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int N_DATA = 2,
    parameter int CTRL_W = 2,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [N_DATA*DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0]        in_wraddr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [N_DATA*DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0]        out_wraddr,
    output logic [1:0]               occupancy,
    output logic [CNT_W-1:0]         bubble_cnt
);

    localparam int DW = N_DATA * DATA_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q;
    logic               in_ready_q;
    logic [CTRL_W-1:0]  head_ctrl_q, skid_ctrl_q;
    logic [DW-1:0]      head_data_q, skid_data_q;
    logic [ADDR_W-1:0]  head_addr_q, skid_addr_q;
    logic [CNT_W-1:0]   bubble_q, bubble_d;

    logic accept, drain;

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid && out_ready;

    // Idle cycles seen by the consumer; flush cycles are excluded.
    always_comb begin
        bubble_d = bubble_q;
        if (!flush && out_ready && (state_q == EMPTY) && (bubble_q != {CNT_W{1'b1}}))
            bubble_d = bubble_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            head_ctrl_q <= '0;
            head_data_q <= '0;
            head_addr_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_addr_q <= '0;
            bubble_q    <= '0;
        end else begin
            bubble_q <= bubble_d;
            if (flush) begin
                // Head data/address are left as-is so the outputs hold their last value.
                state_q    <= EMPTY;
                in_ready_q <= 1'b1;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            head_ctrl_q <= in_ctrl;
                            head_data_q <= in_data;
                            head_addr_q <= in_wraddr;
                            state_q     <= ONE;
                        end
                    end
                    ONE: begin
                        if (accept && drain) begin
                            head_ctrl_q <= in_ctrl;
                            head_data_q <= in_data;
                            head_addr_q <= in_wraddr;
                        end else if (accept) begin
                            skid_ctrl_q <= in_ctrl;
                            skid_data_q <= in_data;
                            skid_addr_q <= in_wraddr;
                            state_q     <= FULL;
                            in_ready_q  <= 1'b0;
                        end else if (drain) begin
                            state_q <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (drain) begin
                            head_ctrl_q <= skid_ctrl_q;
                            head_data_q <= skid_data_q;
                            head_addr_q <= skid_addr_q;
                            state_q     <= ONE;
                            in_ready_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q    <= EMPTY;
                        in_ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != EMPTY);
    assign out_ctrl   = out_valid ? head_ctrl_q : '0;
    assign out_data   = head_data_q;
    assign out_wraddr = head_addr_q;
    assign occupancy  = (state_q == FULL) ? 2'd2 : ((state_q == ONE) ? 2'd1 : 2'd0);
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed vector bench for pipe_stage_reg (CNT_W=4 so saturation is reachable quickly).
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  in_ctrl, out_ctrl, occupancy;
    logic [63:0] in_data, out_data;
    logic [4:0]  in_wraddr, out_wraddr;
    logic [3:0]  bubble_cnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W(32), .N_DATA(2), .CTRL_W(2), .ADDR_W(5), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_wraddr(in_wraddr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .out_wraddr(out_wraddr),
        .occupancy(occupancy), .bubble_cnt(bubble_cnt)
    );

    typedef struct packed {
        logic        rst, flush, iv;
        logic [1:0]  ctrl;
        logic [63:0] data;
        logic [4:0]  addr;
        logic        ordy;
        logic        e_ov, e_ir;
        logic [1:0]  e_occ, e_ctrl;
        logic [63:0] e_data;
        logic [4:0]  e_addr;
        logic [3:0]  e_bub;
    } vec_t;

    function automatic vec_t mk(logic r, logic f, logic iv, logic [1:0] c, logic [63:0] d,
                                logic [4:0] a, logic ordy, logic e_ov, logic e_ir,
                                logic [1:0] e_occ, logic [1:0] e_ctrl, logic [63:0] e_d,
                                logic [4:0] e_a, logic [3:0] e_b);
        vec_t v;
        v = {r, f, iv, c, d, a, ordy, e_ov, e_ir, e_occ, e_ctrl, e_d, e_a, e_b};
        return v;
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(logic r, logic f, logic iv, logic [1:0] c, logic [63:0] d,
                         logic [4:0] a, logic ordy);
        rst = r; flush = f; in_valid = iv; in_ctrl = c; in_data = d; in_wraddr = a;
        out_ready = ordy;
    endtask

    localparam logic [63:0] DA = {32'hAAAA0001, 32'h55550002};

    vec_t vecs [19];

    initial begin
        // rst flush iv ctrl data addr ordy | ov ir occ ctrl data addr bub
        vecs[0]  = mk(1,0,0,2'b00,64'h0,5'd0,0,  0,1,2'd0,2'b00,64'h0,5'd0,4'd0);
        vecs[1]  = mk(0,0,1,2'b01,DA   ,5'd7,1,  1,1,2'd1,2'b01,DA   ,5'd7,4'd1);
        vecs[2]  = mk(0,0,0,2'b00,64'h0,5'd0,1,  0,1,2'd0,2'b00,DA   ,5'd7,4'd1);
        vecs[3]  = mk(0,0,1,2'b01,64'h1,5'd1,0,  1,1,2'd1,2'b01,64'h1,5'd1,4'd1);
        vecs[4]  = mk(0,0,1,2'b11,64'h2,5'd2,0,  1,0,2'd2,2'b01,64'h1,5'd1,4'd1);
        vecs[5]  = mk(0,0,1,2'b01,64'h3,5'd3,0,  1,0,2'd2,2'b01,64'h1,5'd1,4'd1);
        vecs[6]  = mk(0,0,1,2'b01,64'h3,5'd3,1,  1,1,2'd1,2'b11,64'h2,5'd2,4'd1);
        vecs[7]  = mk(0,0,1,2'b01,64'h3,5'd3,1,  1,1,2'd1,2'b01,64'h3,5'd3,4'd1);
        vecs[8]  = mk(0,0,0,2'b00,64'h0,5'd0,1,  0,1,2'd0,2'b00,64'h3,5'd3,4'd1);
        vecs[9]  = mk(0,0,1,2'b01,64'h4,5'd4,0,  1,1,2'd1,2'b01,64'h4,5'd4,4'd1);
        vecs[10] = mk(0,0,1,2'b10,64'h5,5'd5,0,  1,0,2'd2,2'b01,64'h4,5'd4,4'd1);
        vecs[11] = mk(0,1,1,2'b01,64'h6,5'd6,0,  0,1,2'd0,2'b00,64'h4,5'd4,4'd1);
        vecs[12] = mk(0,0,0,2'b00,64'h0,5'd0,1,  0,1,2'd0,2'b00,64'h4,5'd4,4'd2);
        vecs[13] = mk(0,1,0,2'b00,64'h0,5'd0,1,  0,1,2'd0,2'b00,64'h4,5'd4,4'd2);
        vecs[14] = mk(0,0,1,2'b01,64'h7,5'd8,0,  1,1,2'd1,2'b01,64'h7,5'd8,4'd2);
        vecs[15] = mk(0,0,1,2'b01,64'h8,5'd9,0,  1,0,2'd2,2'b01,64'h7,5'd8,4'd2);
        vecs[16] = mk(1,0,0,2'b00,64'h0,5'd0,1,  0,1,2'd0,2'b00,64'h0,5'd0,4'd0);
        vecs[17] = mk(0,0,0,2'b00,64'h0,5'd0,1,  0,1,2'd0,2'b00,64'h0,5'd0,4'd1);
        vecs[18] = mk(0,0,0,2'b00,64'h0,5'd0,1,  0,1,2'd0,2'b00,64'h0,5'd0,4'd2);

        drive(1, 0, 0, 2'b00, 64'h0, 5'd0, 0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].ctrl, vecs[i].data,
                  vecs[i].addr, vecs[i].ordy);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i),
                  128'({out_valid, in_ready, occupancy, out_ctrl, out_data, out_wraddr, bubble_cnt}),
                  128'({vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_occ, vecs[i].e_ctrl,
                        vecs[i].e_data, vecs[i].e_addr, vecs[i].e_bub}));
        end

        // in_ready must not react combinationally to out_ready while FULL.
        drive(0, 0, 1, 2'b01, 64'h10, 5'd10, 0);
        @(posedge clk); #1;
        drive(0, 0, 1, 2'b01, 64'h11, 5'd11, 0);
        @(posedge clk); #1;
        check("full_occ", 128'(occupancy), 128'(2'd2));
        drive(0, 0, 0, 2'b00, 64'h0, 5'd0, 1);
        #1;
        check("ready_no_comb_path", 128'(in_ready), 128'(1'b0));
        @(posedge clk); #1;
        check("ready_after_drain", 128'({in_ready, occupancy, out_data}), 128'({1'b1, 2'd1, 64'h11}));

        // Bubble counter saturation after a fresh reset.
        drive(1, 0, 0, 2'b00, 64'h0, 5'd0, 1);
        @(posedge clk); #1;
        check("bubble_reset", 128'(bubble_cnt), 128'(4'd0));
        drive(0, 0, 0, 2'b00, 64'h0, 5'd0, 1);
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk); #1;
            check($sformatf("bubble_k%0d", k), 128'(bubble_cnt), 128'((k > 15) ? 15 : k));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
